// File: rtl/ray_result_collector.sv
// Purpose: drains finished pixel results from per-core FIFOs in round-robin order and writes them to the framebuffer.
// Latency: one cycle from a non-empty FIFO head at the scan pointer to fb_wr_valid; at best one pixel every two cycles.
// Backpressure: while fb_wr_ready is low the pending write holds addr/data and no further FIFO is popped.
module ray_result_collector #(
  parameter int RAY_CORE_SIZE = 4,
  parameter int COORD_W       = 10,
  parameter int FB_WIDTH      = 160,
  parameter int FB_HEIGHT     = 120,
  parameter int COLOR_W       = 24,
  parameter int ADDR_W        = 15
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               frame_start,
  input  logic [RAY_CORE_SIZE-1:0]           core_empty,
  input  logic [RAY_CORE_SIZE*COORD_W-1:0]   core_x,
  input  logic [RAY_CORE_SIZE*COORD_W-1:0]   core_y,
  input  logic [RAY_CORE_SIZE*COLOR_W-1:0]   core_color,
  output logic [RAY_CORE_SIZE-1:0]           core_rd_en,
  output logic                               fb_wr_valid,
  output logic [ADDR_W-1:0]                  fb_wr_addr,
  output logic [COLOR_W-1:0]                 fb_wr_data,
  input  logic                               fb_wr_ready,
  output logic [ADDR_W-1:0]                  pixel_count,
  output logic                               frame_finished,
  output logic                               err_oob
);

  localparam int                CUR_W    = (RAY_CORE_SIZE > 1) ? $clog2(RAY_CORE_SIZE) : 1;
  localparam logic [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_WIDTH);
  localparam logic [ADDR_W-1:0] TOTAL    = ADDR_W'(FB_WIDTH * FB_HEIGHT);
  localparam logic [CUR_W-1:0]  CUR_LAST = CUR_W'(RAY_CORE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

  state_t             state;
  logic [CUR_W-1:0]   cur;
  logic [CUR_W-1:0]   cur_next;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic [COLOR_W-1:0] head_color;
  logic               head_vld;
  logic               in_range;
  logic [ADDR_W-1:0]  head_addr;
  logic [ADDR_W-1:0]  pixel_count_inc;

  // Head-of-FIFO view for the core under the scan pointer, and its linear address.
  // Address math wraps in ADDR_W bits; only in-range results are ever written, so no overflow reaches the port.
  always_comb begin
    head_x          = core_x[int'(cur)*COORD_W +: COORD_W];
    head_y          = core_y[int'(cur)*COORD_W +: COORD_W];
    head_color      = core_color[int'(cur)*COLOR_W +: COLOR_W];
    head_vld        = !core_empty[cur];
    in_range        = (int'(head_x) < FB_WIDTH) && (int'(head_y) < FB_HEIGHT);
    head_addr       = ADDR_W'(head_y) * FB_W_A + ADDR_W'(head_x);
    pixel_count_inc = pixel_count + ADDR_W'(1);
    cur_next        = (cur == CUR_LAST) ? '0 : cur + CUR_W'(1);
  end

  // Pop strobe is combinational so the FIFO advances on the same edge the head is latched.
  always_comb begin
    core_rd_en = '0;
    if (state == SCAN && head_vld) begin
      core_rd_en[cur] = 1'b1;
    end
  end

  // Collection FSM: scan pointer, pending write register, pixel counter and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cur            <= '0;
      pixel_count    <= '0;
      frame_finished <= 1'b0;
      fb_wr_valid    <= 1'b0;
      err_oob        <= 1'b0;
      fb_wr_addr     <= '0;
      fb_wr_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state       <= SCAN;
            pixel_count <= '0;
            err_oob     <= 1'b0;
            cur         <= '0;
          end
        end
        SCAN: begin
          // The pointer moves every scan cycle, popped or not, so no core can be starved.
          cur <= cur_next;
          if (head_vld) begin
            fb_wr_addr <= head_addr;
            fb_wr_data <= head_color;
            if (in_range) begin
              state       <= WRITE;
              fb_wr_valid <= 1'b1;
            end else begin
              err_oob <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (fb_wr_ready) begin
            fb_wr_valid <= 1'b0;
            pixel_count <= pixel_count_inc;
            if (pixel_count_inc == TOTAL) begin
              state          <= DONE;
              frame_finished <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end
        DONE: begin
          if (frame_start) begin
            state          <= SCAN;
            pixel_count    <= '0;
            err_oob        <= 1'b0;
            frame_finished <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_result_collector.sv
// Bench for ray_result_collector: bench-side FIFOs feed the cores, a frame-level model predicts the write stream,
// and directed scenarios add hand-computed probes at key cycles.
module tb_ray_result_collector;

  localparam int N     = 4;
  localparam int CW    = 10;
  localparam int FBW   = 160;
  localparam int FBH   = 120;
  localparam int COLW  = 24;
  localparam int AW    = 15;
  localparam int TOTAL = FBW * FBH;

  typedef struct packed {
    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic [COLW-1:0] c;
  } res_t;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [COLW-1:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            frame_start;
  logic [N-1:0]    core_empty;
  logic [N*CW-1:0] core_x;
  logic [N*CW-1:0] core_y;
  logic [N*COLW-1:0] core_color;
  logic [N-1:0]    core_rd_en;
  logic            fb_wr_valid;
  logic [AW-1:0]   fb_wr_addr;
  logic [COLW-1:0] fb_wr_data;
  logic            fb_wr_ready;
  logic [AW-1:0]   pixel_count;
  logic            frame_finished;
  logic            err_oob;

  always #5 clk = ~clk;

  ray_result_collector #(
    .RAY_CORE_SIZE(N), .COORD_W(CW), .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .COLOR_W(COLW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .core_empty(core_empty), .core_x(core_x), .core_y(core_y), .core_color(core_color),
    .core_rd_en(core_rd_en), .fb_wr_valid(fb_wr_valid), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .fb_wr_ready(fb_wr_ready), .pixel_count(pixel_count),
    .frame_finished(frame_finished), .err_oob(err_oob)
  );

  // Bench-side result FIFOs (first-word-fall-through), owned by the stimulus process.
  res_t fq[N][$];
  int   epoch = 0;

  // Written only by the compare process.
  logic [N-1:0] pending_pop = '0;
  int   nvec = 0;
  int   nerr = 0;

  // Hand-computed probe, written by the stimulus, checked at the next falling edge.
  int              probe_seq = 0;
  string           p_name;
  logic [N-1:0]    p_rd;
  bit              p_chk_rd, p_chk_dat, p_timeout;
  logic            p_valid, p_err, p_fin;
  logic [AW-1:0]   p_addr, p_count;
  logic [COLW-1:0] p_data;

  // ---------------- compare process and frame-level model ----------------
  wr_t  exp_wr[$];
  int   m_count = 0;
  bit   m_err = 0, m_fin = 0, m_armed = 0;
  bit   started = 0;
  int   seen_seq = 0;
  int   last_core = -1;
  int   last_epoch = 0;
  int   starve = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [N-1:0] rd;
    int   k;
    int   j;
    int   a;
    bit   scanning;
    bit   any_ne;
    res_t it;
    rd = core_rd_en;
    if (!started) begin
      if (reset) started = 1;
      pending_pop = '0;
    end else begin
      if (probe_seq != seen_seq) begin
        seen_seq = probe_seq;
        if (p_timeout) begin
          nvec++;
          nerr++;
          $display("FAIL %s: expected event did not occur within its cycle budget (t=%0t)", p_name, $time);
        end else begin
          if (p_chk_rd) chk({p_name, " core_rd_en"}, 32'(rd), 32'(p_rd));
          chk({p_name, " fb_wr_valid"}, 32'(fb_wr_valid), 32'(p_valid));
          if (p_chk_dat) begin
            chk({p_name, " fb_wr_addr"}, 32'(fb_wr_addr), 32'(p_addr));
            chk({p_name, " fb_wr_data"}, 32'(fb_wr_data), 32'(p_data));
          end
          chk({p_name, " pixel_count"}, 32'(pixel_count), 32'(p_count));
          chk({p_name, " err_oob"}, 32'(err_oob), 32'(p_err));
          chk({p_name, " frame_finished"}, 32'(frame_finished), 32'(p_fin));
        end
      end

      // A write is outstanding exactly when the model holds an accepted-but-unwritten pixel.
      scanning = m_armed && !m_fin && (exp_wr.size() == 0);
      any_ne = 0;
      for (int q = 0; q < N; q++) if (fq[q].size() != 0) any_ne = 1;
      chk("model fb_wr_valid", 32'(fb_wr_valid), 32'(exp_wr.size() != 0));
      if (exp_wr.size() != 0) begin
        chk("model fb_wr_addr", 32'(fb_wr_addr), 32'(exp_wr[0].addr));
        chk("model fb_wr_data", 32'(fb_wr_data), 32'(exp_wr[0].data));
      end
      chk("model pixel_count", 32'(pixel_count), 32'(m_count));
      chk("model err_oob", 32'(err_oob), 32'(m_err));
      chk("model frame_finished", 32'(frame_finished), 32'(m_fin));

      if (!scanning) begin
        chk("model core_rd_en outside scan", 32'(rd), 32'd0);
        starve = 0;
      end else begin
        chk("model core_rd_en one-hot", 32'($countones(rd) <= 1), 32'd1);
        if (any_ne) begin
          if (rd == '0) starve++;
          else starve = 0;
          chk("model pop within one scan round", 32'(starve < N), 32'd1);
        end else begin
          starve = 0;
        end
      end

      // Accept of the outstanding write.
      if (fb_wr_valid && fb_wr_ready && exp_wr.size() != 0) begin
        void'(exp_wr.pop_front());
        m_count++;
        if (m_count == TOTAL) m_fin = 1;
      end

      // Pop: predict the write (or the drop) from the bench FIFO head.
      if (scanning && $countones(rd) == 1) begin
        k = 0;
        for (int q = 0; q < N; q++) if (rd[q]) k = q;
        chk("model pop from non-empty core", 32'(fq[k].size() != 0), 32'd1);
        if (fq[k].size() != 0) begin
          if (last_core >= 0 && last_epoch == epoch) begin
            j = -1;
            for (int s = 1; s <= N; s++)
              if (j < 0 && fq[(last_core + s) % N].size() != 0) j = (last_core + s) % N;
            chk("model round-robin core", 32'(k), 32'(j));
          end
          last_core  = k;
          last_epoch = epoch;
          it = fq[k][0];
          if (int'(it.x) < FBW && int'(it.y) < FBH) begin
            a = int'(it.y) * FBW + int'(it.x);
            exp_wr.push_back('{addr: AW'(a), data: it.c});
          end else begin
            m_err = 1;
          end
        end
      end

      if (frame_start && (!m_armed || m_fin)) begin
        m_count = 0;
        m_err   = 0;
        m_fin   = 0;
        m_armed = 1;
      end

      if (reset) begin
        m_count = 0;
        m_err   = 0;
        m_fin   = 0;
        m_armed = 0;
        exp_wr.delete();
        last_core = -1;
        starve    = 0;
      end
      pending_pop = rd;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      core_empty[k] = (fq[k].size() == 0);
      if (fq[k].size() != 0) begin
        core_x[k*CW +: CW]         = fq[k][0].x;
        core_y[k*CW +: CW]         = fq[k][0].y;
        core_color[k*COLW +: COLW] = fq[k][0].c;
      end else begin
        core_x[k*CW +: CW]         = '0;
        core_y[k*CW +: CW]         = '0;
        core_color[k*COLW +: COLW] = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (pending_pop[k] === 1'b1 && fq[k].size() != 0) void'(fq[k].pop_front());
    refresh();
    #1;
  endtask

  task automatic push(input int core, input int x, input int y, input int c);
    res_t r;
    r.x = CW'(x);
    r.y = CW'(y);
    r.c = COLW'(c);
    fq[core].push_back(r);
    epoch++;
    refresh();
  endtask

  task automatic probe(input string nm, input logic [N-1:0] rd, input bit chk_rd, input logic v,
                       input int a, input int d, input bit chk_dat, input int cnt, input logic e, input logic f);
    p_name    = nm;
    p_rd      = rd;
    p_chk_rd  = chk_rd;
    p_valid   = v;
    p_addr    = AW'(a);
    p_data    = COLW'(d);
    p_chk_dat = chk_dat;
    p_count   = AW'(cnt);
    p_err     = e;
    p_fin     = f;
    p_timeout = 0;
    probe_seq++;
  endtask

  task automatic timeout_fail(input string nm);
    p_name    = nm;
    p_timeout = 1;
    probe_seq++;
    tick();
  endtask

  task automatic wait_pop(input string nm);
    bit seen;
    seen = 0;
    #1;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (core_rd_en != '0) seen = 1;
      else tick();
    end
    if (!seen) timeout_fail(nm);
  endtask

  task automatic wait_cnt(input string nm, input int target, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (int'(pixel_count) == target) seen = 1;
      else tick();
    end
    if (!seen) timeout_fail(nm);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    frame_start = 1'b0;
    fb_wr_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int pushed;
    int cyc;
    reset       = 1'b1;
    frame_start = 1'b0;
    fb_wr_ready = 1'b1;
    core_empty  = '1;
    core_x      = '0;
    core_y      = '0;
    core_color  = '0;
    refresh();

    // 1: single pixel from core0, addr = 2*160+3 = 323
    do_reset();
    push(0, 3, 2, 32'h112233);
    frame_start = 1'b1;
    probe("reset state", 4'b0000, 1, 0, 0, 0, 1, 0, 0, 0);
    tick();
    frame_start = 1'b0;
    probe("t1 pop", 4'b0001, 1, 0, 0, 0, 1, 0, 0, 0);
    tick();
    probe("t1 write", 4'b0000, 1, 1, 323, 32'h112233, 1, 0, 0, 0);
    tick();
    probe("t1 counted", 4'b0000, 1, 0, 323, 32'h112233, 1, 1, 0, 0);
    tick();

    // 2: all four cores loaded, pops in order 0..3, one every two cycles; addr = 5*160+10+k
    do_reset();
    for (int k = 0; k < N; k++) push(k, 10 + k, 5, 32'hA0000 + k);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      probe("t2 pop", 4'(1 << i), 1, 0, (i == 0) ? 0 : 809 + i, (i == 0) ? 0 : 32'hA0000 + i - 1, 1, i, 0, 0);
      tick();
      probe("t2 write", 4'b0000, 1, 1, 810 + i, 32'hA0000 + i, 1, i, 0, 0);
      tick();
    end
    probe("t2 end", 4'b0000, 1, 0, 813, 32'hA0003, 1, 4, 0, 0);
    tick();

    // 3: backpressure for 5 cycles; addr = 9*160+7 = 1447
    fb_wr_ready = 1'b0;
    push(2, 7, 9, 32'hDEADBE);
    wait_pop("t3 pop");
    probe("t3 pop", 4'b0100, 1, 0, 0, 0, 0, 4, 0, 0);
    tick();
    push(3, 0, 0, 32'h000055);
    for (int i = 0; i < 5; i++) begin
      probe("t3 hold", 4'b0000, 1, 1, 1447, 32'hDEADBE, 1, 4, 0, 0);
      tick();
    end
    fb_wr_ready = 1'b1;
    probe("t3 accept", 4'b0000, 1, 1, 1447, 32'hDEADBE, 1, 4, 0, 0);
    tick();
    probe("t3 next core", 4'b1000, 1, 0, 1447, 32'hDEADBE, 1, 5, 0, 0);
    tick();
    probe("t3 second write", 4'b0000, 1, 1, 0, 32'h55, 1, 5, 0, 0);
    tick();
    probe("t3 done", 4'b0000, 1, 0, 0, 32'h55, 1, 6, 0, 0);
    tick();

    // 4: out-of-range x dropped, then a corner pixel (159,119) -> 19199
    push(1, 160, 0, 32'h777777);
    wait_pop("t4 pop");
    probe("t4 pop", 4'b0010, 1, 0, 0, 0, 0, 6, 0, 0);
    tick();
    probe("t4 dropped", 4'b0000, 1, 0, 0, 0, 0, 6, 1, 0);
    tick();
    push(2, 159, 119, 32'hABCDEF);
    wait_pop("t4 corner pop");
    tick();
    probe("t4 corner write", 4'b0000, 1, 1, 19199, 32'hABCDEF, 1, 6, 1, 0);
    tick();
    probe("t4 corner counted", 4'b0000, 1, 0, 19199, 32'hABCDEF, 1, 7, 1, 0);
    tick();

    // 6: reset while a write is pending; addr = 1*160+1 = 161
    fb_wr_ready = 1'b0;
    push(0, 1, 1, 32'h42);
    wait_pop("t6 pop");
    tick();
    probe("t6 pending", 4'b0000, 1, 1, 161, 32'h42, 1, 7, 1, 0);
    reset = 1'b1;
    tick();
    probe("t6 after reset", 4'b0000, 1, 0, 0, 0, 1, 0, 0, 0);
    tick();
    reset       = 1'b0;
    fb_wr_ready = 1'b1;
    push(1, 5, 5, 32'h9);
    for (int i = 0; i < 4; i++) tick();
    probe("t6 idle no pop", 4'b0000, 1, 0, 0, 0, 1, 0, 0, 0);
    tick();
    for (int k = 0; k < N; k++) fq[k].delete();
    epoch++;
    refresh();

    // 5: full frame of 19200 pixels
    do_reset();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pushed = 0;
    cyc    = 0;
    while (frame_finished !== 1'b1 && cyc < 60000) begin
      for (int k = 0; k < N; k++) begin
        if (pushed < TOTAL && fq[k].size() < 2) begin
          push(k, pushed % FBW, pushed / FBW, pushed);
          pushed++;
        end
      end
      tick();
      cyc++;
    end
    if (frame_finished !== 1'b1) timeout_fail("t5 frame_finished");
    probe("t5 finished", 4'b0000, 1, 0, 0, 0, 0, TOTAL, 0, 1);
    tick();
    push(0, 1, 2, 32'h3);
    push(2, 4, 5, 32'h6);
    for (int i = 0; i < 5; i++) tick();
    probe("t5 no pop when done", 4'b0000, 1, 0, 0, 0, 0, TOTAL, 0, 1);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    probe("t5 restart", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    wait_cnt("t5 drain after restart", 2, 20);
    probe("t5 drained", 4'b0000, 1, 0, 0, 0, 0, 2, 0, 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
